// File: rtl/perf_counter_pkg.sv
// Shared constants and config helpers for the performance counter bank.
// All register addresses are 6-bit word addresses.
package perf_counter_pkg;

   localparam int ADDR_WIDTH = 6;

   localparam logic [ADDR_WIDTH-1:0] COUNT_BASE   = 6'd0;
   localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR  = 6'd32;
   localparam logic [ADDR_WIDTH-1:0] CONTROL_ADDR = 6'd33;

   localparam int CFG_ENABLE_BIT = 0;
   localparam int CFG_EDGE_BIT   = 1;
   localparam int CFG_SEL_LSB    = 8;
   localparam int SEL_WIDTH      = 6;

   localparam int CTRL_ENABLE_BIT = 0;
   localparam int CTRL_CLEAR_BIT  = 1;

   typedef struct packed {
      logic [SEL_WIDTH-1:0] sel;
      logic                 edge_mode;
      logic                 enable;
   } channel_cfg_t;

   // Channel i owns the pair of words starting at COUNT_BASE + 2i.
   function automatic logic [ADDR_WIDTH-1:0] count_addr(input int ch);
      return ADDR_WIDTH'(int'(COUNT_BASE) + 2 * ch);
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] cfg_addr(input int ch);
      return ADDR_WIDTH'(int'(COUNT_BASE) + 2 * ch + 1);
   endfunction

   function automatic channel_cfg_t unpack_cfg(input logic [31:0] word);
      channel_cfg_t c;
      c.enable    = word[CFG_ENABLE_BIT];
      c.edge_mode = word[CFG_EDGE_BIT];
      c.sel       = word[CFG_SEL_LSB +: SEL_WIDTH];
      return c;
   endfunction

   function automatic logic [31:0] pack_cfg(input channel_cfg_t c);
      logic [31:0] w;
      w                            = '0;
      w[CFG_ENABLE_BIT]            = c.enable;
      w[CFG_EDGE_BIT]              = c.edge_mode;
      w[CFG_SEL_LSB +: SEL_WIDTH]  = c.sel;
      return w;
   endfunction

endpackage

// File: rtl/perf_counter_if.sv
// One-cycle register port between the control register unit and the counter bank.
interface perf_counter_if;
   import perf_counter_pkg::*;

   logic                  reg_write_en;
   logic                  reg_read_en;
   logic [ADDR_WIDTH-1:0] reg_addr;
   logic [31:0]           reg_write_data;
   logic [31:0]           reg_read_data;

   modport master (
      output reg_write_en,
      output reg_read_en,
      output reg_addr,
      output reg_write_data,
      input  reg_read_data
   );

   modport slave (
      input  reg_write_en,
      input  reg_read_en,
      input  reg_addr,
      input  reg_write_data,
      output reg_read_data
   );

endinterface

// File: rtl/perf_counter_channel.sv
// One counter channel: config register, event qualifier, wrap detection and
// the clear-all > software write > increment priority chain.
module perf_counter_channel
   import perf_counter_pkg::*;
#(
   parameter int NUM_EVENTS = 16,
   parameter int WIDTH      = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  global_enable,
   input  logic                  clear_all,
   input  logic                  count_write,
   input  logic                  cfg_write,
   input  logic [WIDTH-1:0]      load_value,
   input  channel_cfg_t          cfg_value,
   input  logic [NUM_EVENTS-1:0] event_in,
   input  logic [NUM_EVENTS-1:0] event_prev,
   output logic [WIDTH-1:0]      count,
   output channel_cfg_t          cfg,
   output logic                  overflow_set
);

   logic [63:0] event_wide;
   logic [63:0] prev_wide;
   logic        event_hit;
   logic        event_was;
   logic        qualified;

   // Zero-extending to the full select range makes out-of-range selects read as 0.
   assign event_wide = 64'(event_in);
   assign prev_wide  = 64'(event_prev);
   assign event_hit  = event_wide[cfg.sel];
   assign event_was  = prev_wide[cfg.sel];

   assign qualified    = global_enable && cfg.enable && event_hit
                         && !(cfg.edge_mode && event_was);
   assign overflow_set = qualified && (count == {WIDTH{1'b1}})
                         && !clear_all && !count_write;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear_all) begin
         count <= '0;
      end else if (count_write) begin
         count <= load_value;
      end else if (qualified) begin
         count <= count + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cfg <= '0;
      end else if (cfg_write) begin
         cfg <= cfg_value;
      end
   end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of event counters with a one-cycle register port, sticky overflow
// status and a registered overflow interrupt.
module perf_counter_bank
   import perf_counter_pkg::*;
#(
   parameter int NUM_COUNTERS = 4,
   parameter int NUM_EVENTS   = 16,
   parameter int WIDTH        = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_EVENTS-1:0] event_in,
   perf_counter_if.slave         bus,
   output logic                  overflow_irq
);

   logic [NUM_EVENTS-1:0]   event_prev;
   logic                    global_enable;
   logic [NUM_COUNTERS-1:0] status;
   logic [NUM_COUNTERS-1:0] overflow_set;
   logic [NUM_COUNTERS-1:0] clear_mask;
   logic                    control_write;
   logic                    status_write;
   logic                    clear_all;
   channel_cfg_t            new_cfg;
   logic [31:0]             count_word [NUM_COUNTERS];
   logic [31:0]             cfg_word   [NUM_COUNTERS];
   logic [31:0]             read_value;
   logic                    unused_write_bits;

   assign control_write     = bus.reg_write_en && (bus.reg_addr == CONTROL_ADDR);
   assign status_write      = bus.reg_write_en && (bus.reg_addr == STATUS_ADDR);
   assign clear_all         = control_write && bus.reg_write_data[CTRL_CLEAR_BIT];
   assign clear_mask        = status_write ? bus.reg_write_data[NUM_COUNTERS-1:0] : '0;
   assign new_cfg           = unpack_cfg(bus.reg_write_data);
   assign unused_write_bits = ^bus.reg_write_data;

   for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_channel
      logic [WIDTH-1:0] count;
      channel_cfg_t     cfg;
      logic             count_write;
      logic             cfg_write;

      assign count_write = bus.reg_write_en && (bus.reg_addr == count_addr(i));
      assign cfg_write   = bus.reg_write_en && (bus.reg_addr == cfg_addr(i));

      perf_counter_channel #(
         .NUM_EVENTS (NUM_EVENTS),
         .WIDTH      (WIDTH)
      ) u_channel (
         .clk           (clk),
         .reset_n       (reset_n),
         .global_enable (global_enable),
         .clear_all     (clear_all),
         .count_write   (count_write),
         .cfg_write     (cfg_write),
         .load_value    (bus.reg_write_data[WIDTH-1:0]),
         .cfg_value     (new_cfg),
         .event_in      (event_in),
         .event_prev    (event_prev),
         .count         (count),
         .cfg           (cfg),
         .overflow_set  (overflow_set[i])
      );

      assign count_word[i] = 32'(count);
      assign cfg_word[i]   = pack_cfg(cfg);
   end

   // Edge samples run every cycle so a channel switched to edge mode sees true history.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         event_prev    <= '0;
         global_enable <= 1'b0;
      end else begin
         event_prev <= event_in;
         if (control_write) begin
            global_enable <= bus.reg_write_data[CTRL_ENABLE_BIT];
         end
      end
   end

   // A new overflow wins over a write-1-clear landing in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         status       <= '0;
         overflow_irq <= 1'b0;
      end else begin
         status       <= (status & ~clear_mask) | overflow_set;
         overflow_irq <= |status;
      end
   end

   always_comb begin
      read_value = '0;
      for (int c = 0; c < NUM_COUNTERS; c++) begin
         if (bus.reg_addr == count_addr(c)) read_value = count_word[c];
         if (bus.reg_addr == cfg_addr(c))   read_value = cfg_word[c];
      end
      if (bus.reg_addr == STATUS_ADDR)  read_value = 32'(status);
      if (bus.reg_addr == CONTROL_ADDR) read_value = {31'b0, global_enable};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.reg_read_data <= '0;
      end else if (bus.reg_read_en) begin
         bus.reg_read_data <= read_value;
      end
   end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed and randomized checks of perf_counter_bank against an
// arithmetic reference model of the counter bank.
module tb_perf_counter_bank;
   import perf_counter_pkg::*;

   localparam int NC = 4;
   localparam int NE = 16;
   localparam int W  = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [NE-1:0] event_in = '0;
   logic          overflow_irq;
   logic [NE-1:0] cur_ev = '0;

   perf_counter_if bus ();

   perf_counter_bank #(
      .NUM_COUNTERS (NC),
      .NUM_EVENTS   (NE),
      .WIDTH        (W)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .event_in     (event_in),
      .bus          (bus),
      .overflow_irq (overflow_irq)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   int            m_count [NC];
   int            m_en    [NC];
   int            m_edge  [NC];
   int            m_sel   [NC];
   int            m_ovf   [NC];
   int            m_gen;
   logic [NE-1:0] m_prev;
   logic [31:0]   m_rd;
   logic          m_irq;

   task automatic model_reset();
      for (int i = 0; i < NC; i++) begin
         m_count[i] = 0; m_en[i] = 0; m_edge[i] = 0; m_sel[i] = 0; m_ovf[i] = 0;
      end
      m_gen = 0; m_prev = '0; m_rd = '0; m_irq = 1'b0;
   endtask

   function automatic logic [31:0] model_read(input int addr);
      logic [31:0] v;
      v = '0;
      if (addr < 2 * NC) begin
         if (addr % 2 == 0) v = 32'(m_count[addr / 2]);
         else v = 32'(m_en[addr / 2] + 2 * m_edge[addr / 2] + 256 * m_sel[addr / 2]);
      end else if (addr == 32) begin
         for (int i = 0; i < NC; i++) if (m_ovf[i] != 0) v = v + 32'(1 << i);
      end else if (addr == 33) begin
         v = 32'(m_gen);
      end
      return v;
   endfunction

   task automatic model_step(input bit we, input bit re, input int addr,
                             input logic [31:0] wd, input logic [NE-1:0] ev);
      logic [31:0] rd_val;
      bit          any_status;
      bit          clr;
      bit          hit;
      bit          was;
      bit          set_bits [NC];
      rd_val     = model_read(addr);
      any_status = 0;
      for (int i = 0; i < NC; i++) if (m_ovf[i] != 0) any_status = 1;
      clr = we && addr == 33 && wd[1];
      for (int i = 0; i < NC; i++) begin
         hit = (m_sel[i] < NE) ? ev[m_sel[i]] : 1'b0;
         was = (m_sel[i] < NE) ? m_prev[m_sel[i]] : 1'b0;
         set_bits[i] = 0;
         if (clr) m_count[i] = 0;
         else if (we && addr == 2 * i) m_count[i] = int'(wd) & ((1 << W) - 1);
         else if (m_gen != 0 && m_en[i] != 0 && hit && (m_edge[i] == 0 || !was)) begin
            m_count[i] = (m_count[i] + 1) % (1 << W);
            if (m_count[i] == 0) set_bits[i] = 1;
         end
      end
      for (int i = 0; i < NC; i++) begin
         if (we && addr == 32 && wd[i]) m_ovf[i] = 0;
         if (set_bits[i]) m_ovf[i] = 1;
         if (we && addr == 2 * i + 1) begin
            m_en[i] = int'(wd[0]); m_edge[i] = int'(wd[1]); m_sel[i] = int'(wd[13:8]);
         end
      end
      if (we && addr == 33) m_gen = int'(wd[0]);
      if (re) m_rd = rd_val;
      m_irq  = any_status;
      m_prev = ev;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_cycle();
      check_output("read_data", bus.reg_read_data, m_rd);
      check_output("irq", {31'b0, overflow_irq}, {31'b0, m_irq});
   endtask

   task automatic apply_stimulus(input bit we, input bit re, input int addr, input logic [31:0] wd);
      bus.reg_write_en   = we;
      bus.reg_read_en    = re;
      bus.reg_addr       = 6'(addr);
      bus.reg_write_data = wd;
      event_in           = cur_ev;
      model_step(we, re, addr, wd, cur_ev);
      @(posedge clk);
      #1;
      check_cycle();
   endtask

   task automatic wr(input int addr, input logic [31:0] wd);
      apply_stimulus(1'b1, 1'b0, addr, wd);
   endtask

   task automatic rd(input int addr);
      apply_stimulus(1'b0, 1'b1, addr, '0);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b0, 0, '0);
   endtask

   initial begin
      bus.reg_write_en = 1'b0; bus.reg_read_en = 1'b0;
      bus.reg_addr = '0; bus.reg_write_data = '0;
      model_reset();
      #12;
      check_output("reset_read_data", bus.reg_read_data, 32'd0);
      check_output("reset_irq", {31'b0, overflow_irq}, 32'd0);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;

      rd(0);  check_output("reset_count0", bus.reg_read_data, 32'd0);
      rd(33); check_output("reset_control", bus.reg_read_data, 32'd0);

      // Level mode: ch0 on event 3 for ten cycles; ch1 disabled stays at zero.
      wr(1, 32'h0000_0301); wr(33, 32'd1);
      cur_ev[3] = 1'b1; idle(10); cur_ev[3] = 1'b0;
      rd(0); check_output("level_count", bus.reg_read_data, 32'd10);
      rd(2); check_output("disabled_count", bus.reg_read_data, 32'd0);

      // Edge mode: ch1 on event 5, pattern high4 low2 high1.
      wr(3, 32'h0000_0503);
      cur_ev[5] = 1'b1; idle(4); cur_ev[5] = 1'b0; idle(2);
      cur_ev[5] = 1'b1; idle(1); cur_ev[5] = 1'b0;
      rd(2); check_output("edge_count", bus.reg_read_data, 32'd2);

      // Wrap on ch2 from 254 with three events.
      wr(5, 32'h0000_0701); wr(4, 32'd254);
      cur_ev[7] = 1'b1; idle(3); cur_ev[7] = 1'b0;
      check_output("wrap_irq_high", {31'b0, overflow_irq}, 32'd1);
      rd(4);  check_output("wrap_count", bus.reg_read_data, 32'd1);
      rd(32); check_output("wrap_status", bus.reg_read_data, 32'd4);
      wr(32, 32'd4);
      check_output("irq_after_w1c", {31'b0, overflow_irq}, 32'd1);
      idle(1);
      check_output("irq_dropped", {31'b0, overflow_irq}, 32'd0);

      // Collisions.
      cur_ev[3] = 1'b1; wr(0, 32'd100); cur_ev[3] = 1'b0;
      rd(0); check_output("write_beats_incr", bus.reg_read_data, 32'd100);
      wr(4, 32'd255);
      cur_ev[7] = 1'b1; wr(32, 32'd4); cur_ev[7] = 1'b0;
      rd(32); check_output("set_beats_w1c", bus.reg_read_data, 32'd4);
      wr(32, 32'd4); idle(2);
      wr(4, 32'd255);
      cur_ev[7] = 1'b1; wr(33, 32'd3); cur_ev[7] = 1'b0;
      rd(4);  check_output("clear_on_wrap_count", bus.reg_read_data, 32'd0);
      rd(32); check_output("clear_on_wrap_status", bus.reg_read_data, 32'd0);
      rd(0);  check_output("clear_all_ch0", bus.reg_read_data, 32'd0);
      rd(1);  check_output("clear_keeps_cfg", bus.reg_read_data, 32'h0000_0301);
      rd(33); check_output("control_readback", bus.reg_read_data, 32'd1);

      // Register port corner cases.
      rd(40); check_output("unmapped_read", bus.reg_read_data, 32'd0);
      wr(7, 32'h0000_3F01);
      cur_ev = '1; idle(5); cur_ev = '0;
      rd(6); check_output("sel_out_of_range", bus.reg_read_data, 32'd0);
      wr(0, 32'd77);
      apply_stimulus(1'b1, 1'b1, 0, 32'd55);
      check_output("read_during_write", bus.reg_read_data, 32'd77);
      rd(0); check_output("write_after_rdw", bus.reg_read_data, 32'd55);

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         int          op;
         int          pick;
         int          a;
         logic [31:0] d;
         cur_ev = NE'($urandom);
         op     = $urandom_range(0, 9);
         pick   = $urandom_range(0, 10);
         a      = (pick < 8) ? pick : (pick == 8) ? 32 : (pick == 9) ? 33 : 34 + $urandom_range(0, 29);
         d      = $urandom;
         if (a == 33) d = {30'b0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) != 0)};
         else if (a < 8 && a % 2 == 1) begin
            d[13:8] = 6'($urandom_range(0, 18));
            d[0]    = ($urandom_range(0, 3) != 0);
         end else if (a < 8 && $urandom_range(0, 1) == 1) d[7:0] = 8'(250 + $urandom_range(0, 5));
         if (op < 3)       apply_stimulus(1'b1, 1'b0, a, d);
         else if (op < 6)  apply_stimulus(1'b0, 1'b1, a, d);
         else if (op == 6) apply_stimulus(1'b1, 1'b1, a, d);
         else              apply_stimulus(1'b0, 1'b0, a, d);
      end

      // Asynchronous reset in the middle of counting with irq pending.
      cur_ev = '0;
      wr(1, 32'h0000_0301); wr(33, 32'd1); wr(0, 32'd9);
      wr(5, 32'h0000_0301); wr(4, 32'd255);
      cur_ev[3] = 1'b1; idle(1); cur_ev[3] = 1'b0; idle(1);
      rd(0); check_output("pre_reset_count", bus.reg_read_data, 32'd10);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_output("async_reset_read_data", bus.reg_read_data, 32'd0);
      check_output("async_reset_irq", {31'b0, overflow_irq}, 32'd0);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      cur_ev = '1;
      for (int a = 0; a < 2 * NC; a++) begin
         rd(a); check_output("post_reset_reg", bus.reg_read_data, 32'd0);
      end
      rd(32); check_output("post_reset_status", bus.reg_read_data, 32'd0);
      rd(33); check_output("post_reset_control", bus.reg_read_data, 32'd0);
      cur_ev = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
